// File: rtl/kogge_stone_pipe.sv
// kogge_stone_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready
// handshakes on both sides and a single global stall.
//
// Parameters
//   WIDTH      operand/sum width (>= 2); LEVELS = ceil(log2(WIDTH)) prefix levels
//   REG_EVERY  a register follows prefix level k when k % REG_EVERY == 0 and k < LEVELS
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready is combinational)
//   in_a, in_b            operands
//   in_cin                carry-in (ignored when in_sub = 1)
//   in_sub                1: a + ~b + 1, 0: a + b + cin
//   out_valid / out_ready result beat handshake
//   out_sum, out_cout     result and MSB carry-out (sub: 1 = no borrow)
//   out_ovf               signed overflow, present only with KOGGE_STONE_OVF_EN
//
// Optional feature macro: KOGGE_STONE_OVF_EN
module kogge_stone_pipe #(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef KOGGE_STONE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LEVELS = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  // g/p evolve through the prefix tree; p0 (bitwise propagate) and cin ride
  // along unchanged for the final sum.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p0;
    logic             cin;
  } beat_t;

  logic  advance;
  beat_t lvl      [LEVELS+1];
  logic  vld_pipe [LEVELS+1];

  // Global stall: everything moves together whenever the output slot frees.
  logic out_valid_q;
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // ---------------- S0 input register ----------------
  logic [WIDTH-1:0] b_eff;
  beat_t s0_d, s0_q;
  logic  s0_vld_d, s0_vld_q;

  assign b_eff = in_b ^ {WIDTH{in_sub}};

  always_comb begin
    s0_d.p   = in_a ^ b_eff;
    s0_d.g   = in_a & b_eff;
    s0_d.p0  = in_a ^ b_eff;
    s0_d.cin = in_sub | in_cin;
    s0_vld_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q     <= '0;
      s0_vld_q <= 1'b0;
    end else if (advance) begin
      s0_vld_q <= s0_vld_d;
      if (s0_vld_d) s0_q <= s0_d;
    end
  end

  assign lvl[0]      = s0_q;
  assign vld_pipe[0] = s0_vld_q;

  // ---------------- prefix levels ----------------
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int DIST = 1 << (k - 1);
    beat_t src, lvl_d;

    always_comb begin
      src = lvl[k-1];
      // Fold cin into bit 0 before level 1 so every span that reaches bit 0
      // (including position 1 at this level) sees the carry-in.
      if (k == 1) src.g[0] = lvl[k-1].g[0] | (lvl[k-1].p[0] & lvl[k-1].cin);
      lvl_d = src;
      for (int i = DIST; i < WIDTH; i++) begin
        lvl_d.g[i] = src.g[i] | (src.p[i] & src.g[i-DIST]);
        lvl_d.p[i] = src.p[i] & src.p[i-DIST];
      end
    end

    if ((k < LEVELS) && (k % REG_EVERY == 0)) begin : g_reg
      beat_t lvl_q;
      logic  vld_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lvl_q <= '0;
          vld_q <= 1'b0;
        end else if (advance) begin
          vld_q <= vld_pipe[k-1];
          if (vld_pipe[k-1]) lvl_q <= lvl_d;
        end
      end
      assign lvl[k]      = lvl_q;
      assign vld_pipe[k] = vld_q;
    end else begin : g_comb
      assign lvl[k]      = lvl_d;
      assign vld_pipe[k] = vld_pipe[k-1];
    end
  end

  // ---------------- output stage ----------------
  logic [WIDTH-1:0] carry;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_sum_d, out_sum_q;
  logic             out_cout_d, out_cout_q;
  logic             out_ovf_d, out_ovf_q;

  always_comb begin
    carry       = lvl[LEVELS].g;
    out_valid_d = vld_pipe[LEVELS];
    out_sum_d   = lvl[LEVELS].p0 ^ {carry[WIDTH-2:0], lvl[LEVELS].cin};
    out_cout_d  = carry[WIDTH-1];
    out_ovf_d   = carry[WIDTH-2] ^ carry[WIDTH-1];
  end

  // Result fields only load with a valid beat, so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        out_sum_q  <= out_sum_d;
        out_cout_q <= out_cout_d;
        out_ovf_q  <= out_ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
`ifdef KOGGE_STONE_OVF_EN
  assign out_ovf   = out_ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = out_ovf_q;
`endif

endmodule

// File: tb/tb_kogge_stone_pipe.sv
// Bench for kogge_stone_pipe: directed table on a WIDTH=16/REG_EVERY=2 unit,
// back-pressure and mid-flight reset sequences, plus randomized sweeps over
// several WIDTH/REG_EVERY configurations against an arithmetic model.
module tb_kogge_stone_pipe;

  localparam int NCFG  = 7;
  localparam int NBEAT = 800;

  function automatic int cfg_w(input int i);
    case (i)
      0: return 2;
      1: return 8;
      2: return 13;
      3: return 13;
      4: return 16;
      5: return 32;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_re(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 1;
      5: return 2;
      default: return 5;
    endcase
  endfunction

  int n_chk  = 0;
  int n_err  = 0;
  int n_done = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // ---------------- main WIDTH=16, REG_EVERY=2 unit ----------------
  logic        rst_n, in_valid, in_ready, in_cin, in_sub;
  logic        out_valid, out_ready, out_cout;
  logic [15:0] in_a, in_b, out_sum;
`ifdef KOGGE_STONE_OVF_EN
  logic        out_ovf;
`endif

  kogge_stone_pipe #(.WIDTH(16), .REG_EVERY(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
`ifdef KOGGE_STONE_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  // {cout, sum} from plain integer arithmetic
  function automatic logic [16:0] ref16(input logic [15:0] a, b, input logic cin, sub);
    logic [16:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else     r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    return r;
  endfunction

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ovf;
  } vec_t;

  vec_t tbl [11];

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; n = 1;
    while (!out_valid && n < 20) begin @(posedge clk); #1 n++; end
    chk($sformatf("vec%0d_latency", idx), 64'(n), 64'd3);
    chk($sformatf("vec%0d_sum", idx), 64'(out_sum), 64'(v.s));
    chk($sformatf("vec%0d_cout", idx), 64'(out_cout), 64'(v.co));
`ifdef KOGGE_STONE_OVF_EN
    chk($sformatf("vec%0d_ovf", idx), 64'(out_ovf), 64'(v.ovf));
`endif
    @(posedge clk); #1;
  endtask

  logic [15:0] bp_a [6], bp_b [6];
  logic        bp_c [6], bp_s [6];
  logic [16:0] bp_exp [6];

  initial begin : main
    int sent, got, cnt;
    logic [15:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;

    //           a         b         cin   sub   sum       cout  ovf
    tbl[0]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[9]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum",   64'(out_sum),   64'd0);
    chk("rst_out_cout",  64'(out_cout),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef KOGGE_STONE_OVF_EN
    chk("rst_out_ovf",   64'(out_ovf),   64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(i, tbl[i]);

    // back-pressure: 6 beats, out_ready low in cycles 4..6
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 16'($urandom); bp_b[i] = 16'($urandom);
      bp_c[i] = 1'($urandom);  bp_s[i] = 1'($urandom);
      bp_exp[i] = ref16(bp_a[i], bp_b[i], bp_c[i], bp_s[i]);
    end
    sent = 0; got = 0; held = '0;
    for (int c = 1; c <= 30; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      if (sent < 6) begin
        in_valid = 1'b1; in_a = bp_a[sent]; in_b = bp_b[sent];
        in_cin = bp_c[sent]; in_sub = bp_s[sent];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
        chk($sformatf("bp_valid_c%0d", c), 64'(out_valid), 64'd1);
        if (c == 4) held = out_sum;
        else chk($sformatf("bp_sum_stable_c%0d", c), 64'(out_sum), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (got < 6) chk($sformatf("bp_result%0d", got), 64'({out_cout, out_sum}), 64'(bp_exp[got]));
        else chk("bp_extra_result", 64'(got), 64'd5);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    chk("bp_result_count", 64'(got), 64'd6);

    // reset mid-flight
    out_ready = 1'b1; in_cin = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1; in_a = 16'h0101; in_b = 16'h0202;
    @(posedge clk); #1 in_a = 16'h0303;
    @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum",   64'(out_sum),   64'd0);
    chk("mid_rst_cout",  64'(out_cout),  64'd0);
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (out_valid) cnt++; end
    chk("mid_rst_no_stale", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    run_vec(99, tbl[0]);

    for (int i = 0; i < 30000 && n_done < NCFG; i++) @(posedge clk);
    chk("sweep_done", 64'(n_done), 64'(NCFG));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // ---------------- randomized sweep ----------------
  for (genvar gi = 0; gi < NCFG; gi++) begin : g_sw
    localparam int W   = cfg_w(gi);
    localparam int RE  = cfg_re(gi);
    localparam int LAT = 2 + ($clog2(W) - 1) / RE;

    logic         rg, gv, grdy, gc, gsub, gov, gordy, gco;
    logic [W-1:0] ga, gb, gsum;
`ifdef KOGGE_STONE_OVF_EN
    logic         govf;
`endif

    kogge_stone_pipe #(.WIDTH(W), .REG_EVERY(RE)) u_sw (
      .clk(clk), .rst_n(rg),
      .in_valid(gv), .in_ready(grdy),
      .in_a(ga), .in_b(gb), .in_cin(gc), .in_sub(gsub),
      .out_valid(gov), .out_ready(gordy),
      .out_sum(gsum), .out_cout(gco)
`ifdef KOGGE_STONE_OVF_EN
      , .out_ovf(govf)
`endif
    );

    // {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic cin, sub);
      logic [W:0]   full, c1;
      logic [W-1:0] be;
      logic         ov;
      be    = sub ? ~b : b;
      c1    = '0;
      c1[0] = sub | cin;
      full  = {1'b0, a} + {1'b0, be} + c1;
      ov    = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
      return {ov, full};
    endfunction

    task automatic cmp_out(input string tag, input logic [W+1:0] e);
      chk($sformatf("w%0d_re%0d_%s", W, RE, tag), 64'({gco, gsum}), 64'(e[W:0]));
`ifdef KOGGE_STONE_OVF_EN
      chk($sformatf("w%0d_re%0d_%s_ovf", W, RE, tag), 64'(govf), 64'(e[W+1]));
`endif
    endtask

    initial begin : drv
      logic [31:0]  r;
      logic [W+1:0] q [$];
      logic [W+1:0] e;
      logic [W-1:0] s_prev;
      int  got, lat_n;
      bit  keep, stall_prev;
      rg = 1'b0; gv = 1'b0; gordy = 1'b0; ga = '0; gb = '0; gc = 1'b0; gsub = 1'b0;
      repeat (3) @(posedge clk); #1 rg = 1'b1;
      @(posedge clk); #1;

      // latency of a lone beat with no stall
      r = $urandom; ga = r[W-1:0];
      r = $urandom; gb = r[W-1:0];
      gc = 1'b1; gsub = 1'b0; gv = 1'b1; gordy = 1'b1;
      e = model(ga, gb, gc, gsub);
      @(posedge clk); #1 gv = 1'b0; lat_n = 1;
      while (!gov && lat_n < 40) begin @(posedge clk); #1 lat_n++; end
      chk($sformatf("w%0d_re%0d_latency", W, RE), 64'(lat_n), 64'(LAT));
      cmp_out("lat_beat", e);
      @(posedge clk); #1;

      got = 0; keep = 0; stall_prev = 0; s_prev = '0;
      for (int cyc = 0; cyc < 8000 && got < NBEAT; cyc++) begin
        if (!keep) begin
          gv = ($urandom % 10) < 7;
          r = $urandom; ga = r[W-1:0];
          r = $urandom; gb = r[W-1:0];
          gc = 1'($urandom); gsub = ($urandom % 3) == 0;
        end
        gordy = ($urandom % 4) != 0;
        @(negedge clk);
        if (stall_prev) begin
          chk($sformatf("w%0d_re%0d_stall_valid", W, RE), 64'(gov), 64'd1);
          chk($sformatf("w%0d_re%0d_stall_sum", W, RE), 64'(gsum), 64'(s_prev));
        end
        if (gov && gordy) begin
          if (q.size() == 0) chk($sformatf("w%0d_re%0d_extra", W, RE), 64'd1, 64'd0);
          else begin e = q.pop_front(); cmp_out("rand", e); got++; end
        end
        if (gv && grdy) q.push_back(model(ga, gb, gc, gsub));
        keep       = gv && !grdy;
        stall_prev = gov && !gordy;
        s_prev     = gsum;
        @(posedge clk); #1;
      end

      gv = 1'b0; gordy = 1'b1;
      repeat (LAT + 4) begin
        @(negedge clk);
        if (gov) begin
          if (q.size() == 0) chk($sformatf("w%0d_re%0d_extra", W, RE), 64'd1, 64'd0);
          else begin e = q.pop_front(); cmp_out("drain", e); end
        end
        @(posedge clk); #1;
      end
      chk($sformatf("w%0d_re%0d_pending", W, RE), 64'(q.size()), 64'd0);
      n_done++;
    end
  end

endmodule
